issue_ctrl: RTL
===============

# issue_ctrl

Dual-issue controller between the instruction-decode FIFO and the two execution pipes. Each cycle it inspects the two decoded head slots and drives `read_en` to pop 0, 1 or 2 of them, issuing them to pipe 0 and pipe 1. It tracks pending long-latency destination registers in a 32-entry scoreboard. It serialises privileged and unknown instructions through a small state machine.

## Interface
- No parameters.
- `clk  in  1  clock`
- `rstn  in  1  reset; synchronous, active-low`
- `flush  in  1  pipeline flush; highest priority`
- `slot0_valid, slot1_valid  in  1  decoder slot holds an instruction (slot0 is older)`
- `cls0, cls1  in  2  class: 00 simple (ALU/branch), 01 long-latency (mem/mul/div), 10 serialising (csr/tlb/cache/idle/eret/ecall/bar/invalid), 11 treated as 10`
- `rd0, rj0, rk0, rd1, rj1, rk1  in  5  register indices; 0 = none`
- `pipe0_ready, pipe1_ready  in  1  pipe can accept an instruction this cycle`
- `wb_valid  in  1  long-latency writeback`
- `wb_rd  in  5  register written back`
- `priv_done  in  1  serialising instruction completed`
- `read_en  out  2  00 none, 01 pop slot0, 11 pop both; 10 never driven`
- `issue0, issue1  out  1  slot0→pipe0, slot1→pipe1 accepted this cycle`
- `sb_busy  out  1  scoreboard non-zero (registered value)`
- `stall_cnt  out  32  cycles with slot0_valid && !issue0`
- `dual_cnt  out  32  cycles with issue1`

## Operation
- Scoreboard `sb[31:1]`: bit r set means r has a pending long-latency write; `sb[0]` is constant 0.
- Hazard for a slot: `sb[rj]|sb[rk]|sb[rd]` using the registered scoreboard. RAW and WAW both stall.
- States: RUN, DRAIN, WAIT_PRIV.
- RUN, slot0 class 00/01: `issue0 = slot0_valid & pipe0_ready & !hazard0`. Class 01 is pipe0-only.
- RUN, slot0 class 1x: if `sb_busy`, no issue and go to DRAIN. Otherwise, if `pipe0_ready`, issue0 alone and go to WAIT_PRIV.
- `issue1` requires all of: `issue0`, `slot1_valid`, `pipe1_ready`, `cls1==00`, `cls0!=1x`, `!hazard1`, and no intra-pair dependency. Intra-pair dependency is `rd0!=0 && rd0 ∈ {rj1,rk1,rd1}`.
- `read_en = {issue1, issue0}`. `issue1` without `issue0` is impossible.
- DRAIN: `read_en=00`. When `!sb_busy && pipe0_ready && slot0_valid`, issue0 and go to WAIT_PRIV.
- WAIT_PRIV: `read_en=00`. On `priv_done`, go to RUN; issuing resumes the next cycle. `priv_done` is ignored in other states.
- Scoreboard update at the clock edge:
  - An issued class-01 slot0 with `rd0!=0` sets `sb[rd0]`.
  - `wb_valid` clears `sb[wb_rd]`.
  - Set and clear of the same register in the same cycle: set wins.
- Flush:
  - Combinationally forces `read_en=00`, `issue0=issue1=0`.
  - At the edge: scoreboard cleared, state → RUN. `wb_valid` in that cycle is ignored.
  - In-flight long-latency ops are killed by the same flush.
  - Counters are not cleared by flush.
- Counters saturate at `0xFFFFFFFF`. `stall_cnt` does not count flush cycles. They are cleared only by reset.

## Timing
- `read_en`, `issue0` and `issue1` are combinational from the current inputs plus registered state and scoreboard, in the same cycle as the FIFO pop.
- Scoreboard, state and counters are registered.
- A consumer of `wb_rd` can issue at the earliest one cycle after the `wb_valid` cycle; there is no same-cycle bypass.
- A serialising instruction with an empty scoreboard issues the same cycle it reaches slot0.
- Reset values:
  - `sb=0`, state RUN, `sb_busy=0`, counters 0.
  - Outputs during reset cycles: `read_en=00`, `issue0=issue1=0`.
- Reset mid-WAIT_PRIV returns to RUN and discards the pending wait.

## Test plan
- Two independent ALU ops (slot0 `rd=3,rj=1`; slot1 `rd=4,rj=2`), both pipes ready → `read_en=11`, `dual_cnt` +1.
- Slot0 load `rd=5`, issued in cycle t. Next pair has slot0 `rj=5` → `read_en=00` until `wb_valid`, `wb_rd=5` at t+3. Issue occurs at t+4; `stall_cnt` +3.
- Pair with slot0 `rd=7` and slot1 `rk=7` → `read_en=01`. Slot1 issues alone next cycle as slot0.
- Slot0 csr while `sb[9]=1` → DRAIN and `read_en=00`. `wb_rd=9` arrives, then issue0 alone. WAIT_PRIV holds `read_en=00` until `priv_done`, then RUN.
- `flush` during WAIT_PRIV with `sb[4]=1` and `wb_valid` same cycle → next cycle RUN, `sb_busy=0`, counters unchanged.
- Same-cycle issue of load `rd=6` and `wb_rd=6` → `sb[6]` remains 1.

Source files
------------

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - dual-issue controller with long-latency scoreboard and serialising FSM
module issue_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        slot0_valid,
  input  logic        slot1_valid,
  input  logic [1:0]  cls0,
  input  logic [1:0]  cls1,
  input  logic [4:0]  rd0,
  input  logic [4:0]  rj0,
  input  logic [4:0]  rk0,
  input  logic [4:0]  rd1,
  input  logic [4:0]  rj1,
  input  logic [4:0]  rk1,
  input  logic        pipe0_ready,
  input  logic        pipe1_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        priv_done,
  output logic [1:0]  read_en,
  output logic        issue0,
  output logic        issue1,
  output logic        sb_busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] dual_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, WAIT_PRIV} state_t;

  state_t      state;
  logic [31:0] sb;
  logic [31:0] sb_next;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic        ser0;
  logic        hazard0;
  logic        hazard1;
  logic        pair_dep;
  logic        go_drain;
  logic        go_wait;

  // sb[0] is always 0, so register index 0 never contributes a hazard
  assign sb_busy = |sb;
  assign read_en = {issue1, issue0};

  // Issue decision: combinational from current slots plus registered state/scoreboard
  always_comb begin
    ser0     = cls0[1];
    hazard0  = sb[rj0] | sb[rk0] | sb[rd0];
    hazard1  = sb[rj1] | sb[rk1] | sb[rd1];
    pair_dep = (rd0 != 5'd0) && ((rd0 == rj1) || (rd0 == rk1) || (rd0 == rd1));
    issue0   = 1'b0;
    go_drain = 1'b0;
    go_wait  = 1'b0;
    case (state)
      RUN: begin
        if (slot0_valid) begin
          if (ser0) begin
            if (sb_busy) begin
              go_drain = 1'b1;
            end else if (pipe0_ready) begin
              issue0  = 1'b1;
              go_wait = 1'b1;
            end
          end else begin
            issue0 = pipe0_ready & ~hazard0;
          end
        end
      end
      DRAIN: begin
        if (!sb_busy && pipe0_ready && slot0_valid) begin
          issue0  = 1'b1;
          go_wait = 1'b1;
        end
      end
      default: ;
    endcase
    // Flush and reset suppress every pop in the same cycle
    if (!rstn || flush) begin
      issue0   = 1'b0;
      go_drain = 1'b0;
      go_wait  = 1'b0;
    end
    issue1 = issue0 & slot1_valid & pipe1_ready & (cls1 == 2'b00) & ~ser0 & ~hazard1 & ~pair_dep;
  end

  // Next scoreboard: writeback clears, issued long-latency slot0 sets; set wins on collision
  always_comb begin
    set_mask = (issue0 && cls0 == 2'b01 && rd0 != 5'd0) ? (32'd1 << rd0) : 32'd0;
    clr_mask = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    sb_next  = ((sb & ~clr_mask) | set_mask) & ~32'd1;
  end

  // Scoreboard register; flush kills in-flight ops and ignores the same-cycle writeback
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      sb <= 32'd0;
    end else begin
      sb <= sb_next;
    end
  end

  // Serialisation FSM: RUN -> DRAIN until scoreboard empties -> WAIT_PRIV until priv_done
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (go_drain) state <= DRAIN;
          else if (go_wait) state <= WAIT_PRIV;
        end
        DRAIN: begin
          if (go_wait) state <= WAIT_PRIV;
        end
        WAIT_PRIV: begin
          if (priv_done) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating performance counters, cleared only by reset; flush cycles are not stalls
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt <= 32'd0;
      dual_cnt  <= 32'd0;
    end else begin
      if (slot0_valid && !issue0 && !flush && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (issue1 && dual_cnt != 32'hFFFF_FFFF)
        dual_cnt <= dual_cnt + 32'd1;
    end
  end

endmodule
